adc_conv_sequencer: RTL and testbench
=====================================

// Module: adc_conv_sequencer
// PURPOSE
// Upstream stage of the parallel-to-serial ADC readout path in the CPLD. Paces sampling from
// the 24 MHz clkin, fires a shared conversion start to all ADC chips, and waits on their BUSY
// outputs. Once every chip has finished, it issues the one-cycle enable pulse that launches the
// serializer, then holds off until the serializer has drained the frame. Overruns and stuck
// handshakes are flagged for the DSP.
// PARAMETERS
// ADC_CHIP_NO   4     number of ADC chips; sets the busy bus width
// SAMPLE_DIV    1500  clkin cycles per sample tick (24 MHz / 1500 = 16 kHz); must be >= 2
// CONVST_LOW    3     cycles convst_bar is held low; must be >= 1
// TIMEOUT       1023  max cycles spent in any wait state before aborting; must be >= 1
// PORTS
// clkin        in   1            24 MHz system clock; all logic on its rising edge
// rst          in   1            synchronous, active-high reset
// run          in   1            level; 1 = sample continuously, 0 = stop after current frame
// busy         in   ADC_CHIP_NO  ADC BUSY outputs, active high, asynchronous to clkin
// ser_busy     in   1            serializer active (its spi_cs low), active high
// clr_err      in   1            one-cycle pulse; clears overrun, timeout_err and ovr_cnt
// convst_bar   out  1            conversion start to all ADC chips, active low
// enable       out  1            one-cycle start pulse to the serializer
// frame_cnt    out  16           completed frames, wraps 0xFFFF -> 0
// ovr_cnt      out  8            dropped sample ticks, saturates at 0xFF
// overrun      out  1            sticky: a tick arrived outside IDLE
// timeout_err  out  1            sticky: a wait state expired
// BEHAVIOUR
// - Reset values: convst_bar=1, enable=0, frame_cnt=0, ovr_cnt=0, overrun=0, timeout_err=0.
//   Also state=IDLE, div_cnt=0, tmo_cnt=0, busy sync flops=0.
// - Reset asserted mid-frame forces all reset values on the next edge; no enable pulse follows.
// - Input sync: busy and ser_busy each pass through 2 flops; FSM reads only the synced copies
//   (bsy_s, sbsy_s). This adds 2 cycles of latency.
// - Divider: when run=0, div_cnt is held at 0. When run=1, div_cnt counts 0..SAMPLE_DIV-1
//   and wraps. tick=1 for the one cycle where div_cnt==SAMPLE_DIV-1, so the first tick comes
//   SAMPLE_DIV cycles after run rises.
// - tmo_cnt is cleared on entry to every wait state and increments each cycle spent in it.
//   On reaching TIMEOUT: set timeout_err and go to IDLE.
// - FSM:
//   IDLE:     on tick -> CONVST.
//   CONVST:   convst_bar=0 for exactly CONVST_LOW cycles, then -> WAIT_HI.
//   WAIT_HI:  when any bit of bsy_s is 1 -> WAIT_LO.
//   WAIT_LO:  when all bits of bsy_s are 0 -> START.
//   START:    enable=1 for exactly one cycle -> WAIT_ACK.
//   WAIT_ACK: when sbsy_s=1 -> WAIT_SER.
//   WAIT_SER: when sbsy_s=0 -> IDLE and frame_cnt+1.
// - A timeout never produces enable and never increments frame_cnt.
// - tick in any state other than IDLE: the sample is dropped. Set overrun and increment
//   ovr_cnt (saturating). The current frame is not disturbed.
// - tick and clr_err in the same cycle: clear wins for the flags. ovr_cnt loads 1 if the tick
//   is an overrun, else 0.
// - run falling mid-frame: the frame completes normally. No new tick is generated because
//   the divider is held at 0.
// - Outputs are registered; convst_bar and enable are glitch-free.
// TESTING
// 1 Nominal: SAMPLE_DIV=16, CONVST_LOW=3; run=1; busy=4'hF for 10 cycles starting 2 cycles after
//   convst_bar falls; ser_busy high for 20 cycles starting 3 cycles after enable.
//   -> convst_bar low 3 cycles at cycle 16; one enable pulse; frame_cnt=1; no flags.
// 2 Skew: chips release busy at staggered times (bit0 first, bit3 last, 5 cycles apart).
//   -> enable follows only the last release, by sync + 1 cycle; no enable after the first release.
// 3 Overrun: SAMPLE_DIV=16; ser_busy held high 40 cycles.
//   -> next tick sets overrun and ovr_cnt=1; frame_cnt advances only once; clr_err -> flags=0.
// 4 Timeout: TIMEOUT=8; busy stuck at 0.
//   -> timeout_err=1 exactly 8 cycles after entering WAIT_HI; state IDLE; no enable.
//   Next tick proceeds normally.
// 5 Reset mid-operation: rst pulse during WAIT_LO.
//   -> next edge: convst_bar=1, counters=0; no enable; first tick SAMPLE_DIV cycles after rst drops.
// 6 Stop: run falls during WAIT_SER.
//   -> frame completes, frame_cnt+1; no further convst_bar activity while run=0.

Source files
------------

// File: rtl/adc_conv_sequencer.sv
// Paces ADC sampling, fires a shared conversion start, waits on chip BUSY, then launches the
// serializer with a one-cycle enable and holds off until it has drained the frame.
module adc_conv_sequencer #(
  parameter int ADC_CHIP_NO = 4,
  parameter int SAMPLE_DIV  = 1500,
  parameter int CONVST_LOW  = 3,
  parameter int TIMEOUT     = 1023
) (
  input  logic                   clkin,
  input  logic                   rst,
  input  logic                   run,
  input  logic [ADC_CHIP_NO-1:0] busy,
  input  logic                   ser_busy,
  input  logic                   clr_err,
  output logic                   convst_bar,
  output logic                   enable,
  output logic [15:0]            frame_cnt,
  output logic [7:0]             ovr_cnt,
  output logic                   overrun,
  output logic                   timeout_err,
  output logic [2:0]             state_dbg
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int CV_W  = (CONVST_LOW > 1) ? $clog2(CONVST_LOW) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CV_W-1:0]  CV_LAST  = CV_W'(CONVST_LOW - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CONVST   = 3'd1,
    ST_WAIT_HI  = 3'd2,
    ST_WAIT_LO  = 3'd3,
    ST_START    = 3'd4,
    ST_WAIT_ACK = 3'd5,
    ST_WAIT_SER = 3'd6
  } state_t;

  state_t                 state_q;
  logic [ADC_CHIP_NO-1:0] bsy_meta_q, bsy_s_q;
  logic                   sbsy_meta_q, sbsy_s_q;
  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic [TMO_W-1:0]       tmo_cnt_q;
  logic [CV_W-1:0]        cv_cnt_q;
  logic                   convst_bar_q, enable_q, overrun_q, timeout_err_q;
  logic [15:0]            frame_cnt_q;
  logic [7:0]             ovr_cnt_q;
  logic                   tick, drop, in_wait, exit_now, tmo_hit;

  // busy and ser_busy are asynchronous to clkin; only the second flop is ever used.
  always_ff @(posedge clkin) begin
    if (rst) begin
      bsy_meta_q  <= '0;
      bsy_s_q     <= '0;
      sbsy_meta_q <= 1'b0;
      sbsy_s_q    <= 1'b0;
    end else begin
      bsy_meta_q  <= busy;
      bsy_s_q     <= bsy_meta_q;
      sbsy_meta_q <= ser_busy;
      sbsy_s_q    <= sbsy_meta_q;
    end
  end

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (!run || div_cnt_q == DIV_LAST) div_cnt_d = '0;
  end

  always_ff @(posedge clkin) begin
    if (rst) div_cnt_q <= '0;
    else     div_cnt_q <= div_cnt_d;
  end

  assign tick = run && (div_cnt_q == DIV_LAST);
  assign drop = tick && (state_q != ST_IDLE);

  always_comb begin
    in_wait  = 1'b0;
    exit_now = 1'b0;
    case (state_q)
      ST_WAIT_HI:  begin in_wait = 1'b1; exit_now = |bsy_s_q;  end
      ST_WAIT_LO:  begin in_wait = 1'b1; exit_now = ~|bsy_s_q; end
      ST_WAIT_ACK: begin in_wait = 1'b1; exit_now = sbsy_s_q;  end
      ST_WAIT_SER: begin in_wait = 1'b1; exit_now = ~sbsy_s_q; end
      default:     begin in_wait = 1'b0; exit_now = 1'b0;      end
    endcase
    tmo_hit = in_wait && !exit_now && (tmo_cnt_q == TMO_LAST);
  end

  // Serializer handshake: enable is a one-cycle request with no ready qualifier; the serializer
  // acknowledges by raising ser_busy and completes the frame by dropping it again.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      tmo_cnt_q     <= '0;
      cv_cnt_q      <= '0;
      convst_bar_q  <= 1'b1;
      enable_q      <= 1'b0;
      frame_cnt_q   <= '0;
      ovr_cnt_q     <= '0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      if (clr_err) begin
        overrun_q     <= 1'b0;
        timeout_err_q <= 1'b0;
        ovr_cnt_q     <= drop ? 8'd1 : 8'd0;
      end else begin
        if (drop) begin
          overrun_q <= 1'b1;
          if (ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
        end
        if (tmo_hit) timeout_err_q <= 1'b1;
      end

      if (in_wait && !exit_now) begin
        if (tmo_hit) state_q   <= ST_IDLE;
        else         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_q      <= ST_CONVST;
            convst_bar_q <= 1'b0;
            cv_cnt_q     <= '0;
          end
        end
        ST_CONVST: begin
          if (cv_cnt_q == CV_LAST) begin
            state_q      <= ST_WAIT_HI;
            convst_bar_q <= 1'b1;
            tmo_cnt_q    <= '0;
          end else begin
            cv_cnt_q <= cv_cnt_q + 1'b1;
          end
        end
        ST_WAIT_HI: begin
          if (exit_now) begin
            state_q   <= ST_WAIT_LO;
            tmo_cnt_q <= '0;
          end
        end
        ST_WAIT_LO: begin
          if (exit_now) begin
            state_q  <= ST_START;
            enable_q <= 1'b1;
          end
        end
        ST_START: begin
          state_q   <= ST_WAIT_ACK;
          enable_q  <= 1'b0;
          tmo_cnt_q <= '0;
        end
        ST_WAIT_ACK: begin
          if (exit_now) begin
            state_q   <= ST_WAIT_SER;
            tmo_cnt_q <= '0;
          end
        end
        ST_WAIT_SER: begin
          if (exit_now) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign convst_bar  = convst_bar_q;
  assign enable      = enable_q;
  assign frame_cnt   = frame_cnt_q;
  assign ovr_cnt     = ovr_cnt_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Bench for adc_conv_sequencer: two instances (long and short timeout) share the stimulus and
// are compared every cycle against a phase/age reference model, plus directed scenario checks.
module tb_adc_conv_sequencer;

  localparam int SD    = 16;
  localparam int CL    = 3;
  localparam int TMO_A = 63;
  localparam int TMO_B = 8;

  localparam int P_IDLE = 0, P_CONV = 1, P_WHI = 2, P_WLO = 3, P_START = 4, P_WACK = 5, P_WSER = 6;

  typedef struct {
    int         ph;
    int         age;
    int         run_edges;
    int         frames;
    int         ovc;
    bit         ovf;
    bit         terr;
    logic [3:0] b1, b2;
    logic       s1, s2;
  } model_t;

  logic        clkin, rst, run, ser_busy, clr_err;
  logic [3:0]  busy;
  logic        convst_bar_a, enable_a, overrun_a, timeout_err_a;
  logic        convst_bar_b, enable_b, overrun_b, timeout_err_b;
  logic [15:0] frame_cnt_a, frame_cnt_b;
  logic [7:0]  ovr_cnt_a, ovr_cnt_b;
  logic [2:0]  state_dbg_a, state_dbg_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_seen = 0;
  int cb_low = 0;
  bit prev_cb = 1'b1;
  bit bsy_auto = 1'b1;
  int bdly[4], blen[4], bon[4], boff[4];
  int sdly, slen, son, soff;
  model_t ma, mb;

  adc_conv_sequencer #(.ADC_CHIP_NO(4), .SAMPLE_DIV(SD), .CONVST_LOW(CL), .TIMEOUT(TMO_A)) dut_a (
    .clkin(clkin), .rst(rst), .run(run), .busy(busy), .ser_busy(ser_busy), .clr_err(clr_err),
    .convst_bar(convst_bar_a), .enable(enable_a), .frame_cnt(frame_cnt_a), .ovr_cnt(ovr_cnt_a),
    .overrun(overrun_a), .timeout_err(timeout_err_a), .state_dbg(state_dbg_a));

  adc_conv_sequencer #(.ADC_CHIP_NO(4), .SAMPLE_DIV(SD), .CONVST_LOW(CL), .TIMEOUT(TMO_B)) dut_b (
    .clkin(clkin), .rst(rst), .run(run), .busy(busy), .ser_busy(ser_busy), .clr_err(clr_err),
    .convst_bar(convst_bar_b), .enable(enable_b), .frame_cnt(frame_cnt_b), .ovr_cnt(ovr_cnt_b),
    .overrun(overrun_b), .timeout_err(timeout_err_b), .state_dbg(state_dbg_b));

  // clock / reset
  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Reference: phase + cycles-in-phase, inputs seen through a two-edge delay.
  function automatic model_t mstep(model_t m, logic r, logic rn, logic [3:0] bz, logic sb,
                                   logic clr, int lim);
    model_t n;
    bit tick, drop, tout;
    int nph;
    n = m;
    if (r) begin
      n.ph = P_IDLE; n.age = 0; n.run_edges = 0; n.frames = 0; n.ovc = 0;
      n.ovf = 1'b0; n.terr = 1'b0; n.b1 = '0; n.b2 = '0; n.s1 = 1'b0; n.s2 = 1'b0;
      return n;
    end
    tick = rn && (m.run_edges % SD == SD - 1);
    drop = tick && (m.ph != P_IDLE);
    tout = 1'b0;
    nph  = m.ph;
    case (m.ph)
      P_IDLE:  if (tick) nph = P_CONV;
      P_CONV:  if (m.age == CL - 1) nph = P_WHI;
      P_WHI:   if (m.b2 != 4'd0) nph = P_WLO;
      P_WLO:   if (m.b2 == 4'd0) nph = P_START;
      P_START: nph = P_WACK;
      P_WACK:  if (m.s2) nph = P_WSER;
      P_WSER:  if (!m.s2) begin nph = P_IDLE; n.frames = (m.frames + 1) % 65536; end
      default: nph = P_IDLE;
    endcase
    if ((m.ph == P_WHI || m.ph == P_WLO || m.ph == P_WACK || m.ph == P_WSER) &&
        nph == m.ph && m.age + 1 == lim) begin
      tout = 1'b1;
      nph  = P_IDLE;
    end
    if (clr) begin
      n.ovf = 1'b0; n.terr = 1'b0; n.ovc = drop ? 1 : 0;
    end else begin
      if (drop) begin n.ovf = 1'b1; if (n.ovc < 255) n.ovc = n.ovc + 1; end
      if (tout) n.terr = 1'b1;
    end
    n.age = (nph != m.ph) ? 0 : m.age + 1;
    n.ph  = nph;
    n.b2 = m.b1; n.b1 = bz; n.s2 = m.s1; n.s1 = sb;
    n.run_edges = rn ? m.run_edges + 1 : 0;
    return n;
  endfunction

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic cmp(input string p, input model_t m, input logic cb, input logic en,
                     input logic [15:0] fc, input logic [7:0] oc, input logic ov,
                     input logic te, input logic [2:0] st);
    chk({p, ".convst_bar"}, cb, m.ph != P_CONV);
    chk({p, ".enable"}, en, m.ph == P_START);
    chk({p, ".frame_cnt"}, fc, m.frames);
    chk({p, ".ovr_cnt"}, oc, m.ovc);
    chk({p, ".overrun"}, ov, m.ovf);
    chk({p, ".timeout_err"}, te, m.terr);
    chk({p, ".idle"}, st == 3'd0, m.ph == P_IDLE);
  endtask

  // driver: one clock, model update, output compare, ADC/serializer responders
  task automatic step();
    @(posedge clkin);
    ma = mstep(ma, rst, run, busy, ser_busy, clr_err, TMO_A);
    mb = mstep(mb, rst, run, busy, ser_busy, clr_err, TMO_B);
    @(negedge clkin);
    cyc++;
    cmp("a", ma, convst_bar_a, enable_a, frame_cnt_a, ovr_cnt_a, overrun_a, timeout_err_a, state_dbg_a);
    cmp("b", mb, convst_bar_b, enable_b, frame_cnt_b, ovr_cnt_b, overrun_b, timeout_err_b, state_dbg_b);
    if (!convst_bar_a) cb_low++;
    if (enable_a) begin
      en_seen++;
      son  = cyc + sdly;
      soff = son + slen;
    end
    if (prev_cb && !convst_bar_a && bsy_auto) begin
      for (int c = 0; c < 4; c++) begin
        bon[c]  = cyc + bdly[c];
        boff[c] = bon[c] + blen[c];
      end
    end
    prev_cb = convst_bar_a;
    for (int c = 0; c < 4; c++) busy[c] = (cyc >= bon[c]) && (cyc < boff[c]);
    ser_busy = (cyc >= son) && (cyc < soff);
  endtask

  task automatic set_cfg(input int bd, input int b0, input int b1v, input int b2v, input int b3,
                         input int sd, input int sl);
    for (int c = 0; c < 4; c++) bdly[c] = bd;
    blen[0] = b0; blen[1] = b1v; blen[2] = b2v; blen[3] = b3;
    sdly = sd; slen = sl;
  endtask

  task automatic rand_cfg();
    for (int c = 0; c < 4; c++) begin
      bdly[c] = int'($urandom_range(1, 4));
      blen[c] = ($urandom_range(0, 19) == 0) ? 70 : int'($urandom_range(0, 20));
    end
    sdly = int'($urandom_range(1, 5));
    slen = ($urandom_range(0, 19) == 0) ? 70 : int'($urandom_range(1, 30));
  endtask

  task automatic wait_fall(input string tag, output int n);
    n = 0;
    while (convst_bar_a && n < 200) begin step(); n++; end
    chk({tag, ".wait_convst"}, n < 200, 1);
  endtask

  task automatic wait_frame(input string tag, input int target);
    int n;
    n = 0;
    while (frame_cnt_a != 16'(target) && n < 400) begin step(); n++; end
    chk({tag, ".frame_cnt"}, frame_cnt_a, target);
  endtask

  initial begin
    int n, w, en0, boff3;
    rst = 1'b1; run = 1'b0; busy = '0; ser_busy = 1'b0; clr_err = 1'b0;
    for (int c = 0; c < 4; c++) begin bon[c] = 0; boff[c] = 0; end
    son = 0; soff = 0;
    set_cfg(2, 10, 10, 10, 10, 3, 20);
    repeat (3) step();
    chk("rst.convst_bar", convst_bar_a, 1);
    chk("rst.enable", enable_a, 0);
    chk("rst.frame_cnt", frame_cnt_a, 0);
    chk("rst.ovr_cnt", ovr_cnt_a, 0);
    chk("rst.overrun", overrun_a, 0);
    chk("rst.timeout_err", timeout_err_a, 0);

    // nominal frame, run dropped once the conversion is under way
    rst = 1'b0; run = 1'b1; en0 = en_seen;
    wait_fall("s1", n);
    chk("s1.first_tick", n, SD);
    n = 0;
    while (!convst_bar_a && n < 20) begin step(); n++; end
    chk("s1.convst_low", n, CL);
    run = 1'b0;
    wait_frame("s1", 1);
    chk("s1.enables", en_seen - en0, 1);
    chk("s1.overrun", overrun_a, 0);
    chk("s1.timeout_err", timeout_err_a, 0);

    // staggered busy release: enable tracks the last chip only
    set_cfg(2, 4, 9, 14, 19, 3, 20);
    en0 = en_seen; run = 1'b1;
    wait_fall("s2", n);
    run = 1'b0; boff3 = boff[3];
    n = 0;
    while (!enable_a && n < 200) begin step(); n++; end
    chk("s2.enable_latency", cyc - boff3, 3);
    wait_frame("s2", 2);
    chk("s2.enables", en_seen - en0, 1);

    // overrun while the serializer is slow
    set_cfg(2, 10, 10, 10, 10, 3, 40);
    run = 1'b1;
    n = 0;
    while (!overrun_a && n < 200) begin step(); n++; end
    run = 1'b0;
    chk("s3.ovr_cnt", ovr_cnt_a, 1);
    wait_frame("s3", 3);
    chk("s3.overrun_sticky", overrun_a, 1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("s3.clr_overrun", overrun_a, 0);
    chk("s3.clr_ovr_cnt", ovr_cnt_a, 0);

    // stuck busy: both instances time out in WAIT_HI
    set_cfg(2, 10, 10, 10, 10, 3, 20);
    bsy_auto = 1'b0; en0 = en_seen; run = 1'b1;
    wait_fall("s4", n);
    run = 1'b0;
    n = 0;
    while (!convst_bar_a && n < 20) begin step(); n++; end
    w = cyc;
    chk("s4.tmo_b_pre", timeout_err_b, 0);
    n = 0;
    while (!timeout_err_b && n < 100) begin step(); n++; end
    chk("s4.tmo_b_latency", cyc - w, TMO_B);
    n = 0;
    while (!timeout_err_a && n < 200) begin step(); n++; end
    chk("s4.tmo_a_latency", cyc - w, TMO_A);
    chk("s4.idle", state_dbg_a, 0);
    chk("s4.enables", en_seen - en0, 0);
    chk("s4.frame_cnt", frame_cnt_a, 3);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    bsy_auto = 1'b1; run = 1'b1;
    wait_fall("s4b", n);
    run = 1'b0;
    wait_frame("s4b", 4);
    chk("s4b.timeout_err", timeout_err_a, 0);

    // reset while in WAIT_LO
    set_cfg(2, 12, 12, 12, 12, 3, 20);
    run = 1'b1;
    wait_fall("s5", n);
    repeat (6) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("s5.convst_bar", convst_bar_a, 1);
    chk("s5.enable", enable_a, 0);
    chk("s5.frame_cnt", frame_cnt_a, 0);
    chk("s5.ovr_cnt", ovr_cnt_a, 0);
    chk("s5.idle", state_dbg_a, 0);
    en0 = en_seen;
    wait_fall("s5", n);
    chk("s5.first_tick", n, SD);
    chk("s5.no_enable", en_seen - en0, 0);
    run = 1'b0;
    wait_frame("s5", 1);

    // run falls during WAIT_SER
    run = 1'b1;
    n = 0;
    while (!enable_a && n < 200) begin step(); n++; end
    repeat (8) step();
    run = 1'b0;
    wait_frame("s6", 2);
    cb_low = 0;
    repeat (40) step();
    chk("s6.quiet", cb_low, 0);

    // randomized traffic
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      clr_err = ($urandom_range(0, 63) == 0);
      rst     = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 15) == 0) rand_cfg();
      step();
    end
    rst = 1'b0; clr_err = 1'b0; run = 1'b0;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
